// File: rtl/ttt_pkg.sv
// Shared types and codes for the tic-tac-toe engine.
package ttt_pkg;

  // Cell contents; the winner encoding reuses the same values.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;

  typedef enum logic [2:0] {IDLE, WAIT_MOVE, SCAN, EVAL, OVER} state_e;
  typedef enum logic [1:0] {DIR_ROW, DIR_COL, DIR_DIAG, DIR_ADIAG} dir_e;

  // Stone code for the side to move (turn: 0 = X, 1 = O).
  function automatic logic [1:0] player_code(input logic turn);
    return turn ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/ttt_game_core_line_scan.sv
// Probe address generator: placed cell + direction + offset -> probe cell.
// Pure signed coordinate arithmetic; off counts 0..2*WIN_LEN-2 and maps to
// the signed step -(WIN_LEN-1)..+(WIN_LEN-1) along the chosen line.
module ttt_line_scan
  import ttt_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  parameter int RC_W    = 2,
  parameter int OFF_W   = 3,
  parameter int CELL_W  = 4
) (
  input  logic [RC_W-1:0]   row,
  input  logic [RC_W-1:0]   col,
  input  dir_e              dir,
  input  logic [OFF_W-1:0]  off,
  output logic              in_bounds,
  output logic [CELL_W-1:0] probe_idx
);

  // Step along the line and flag probes that fall off the board (no wrap).
  always_comb begin
    int d, dr, dc, r, c;
    d  = int'(off) - (WIN_LEN - 1);
    dr = 0;
    dc = 0;
    case (dir)
      DIR_ROW:  dc = d;
      DIR_COL:  dr = d;
      DIR_DIAG: begin dr = d; dc = d;  end
      default:  begin dr = d; dc = -d; end
    endcase
    r = int'(row) + dr;
    c = int'(col) + dc;
    in_bounds = (r >= 0) && (r < BOARD_N) && (c >= 0) && (c < BOARD_N);
    probe_idx = '0;
    if (in_bounds) probe_idx = CELL_W'(r * BOARD_N + c);
  end

endmodule

// File: rtl/ttt_game_core.sv
// Tic-tac-toe engine: N x N board, K-in-a-row win check by a fixed-length
// scan of the four lines through the last placed stone.
// Optional macro TTT_ALT_FIRST_EN: alternate the opening player per game.
module ttt_game_core
  import ttt_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  parameter int CELL_W  = $clog2(BOARD_N*BOARD_N),
  parameter int CNT_W   = $clog2(BOARD_N*BOARD_N+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_pulse,
  input  logic                           key_valid,
  input  logic [CELL_W-1:0]              key_idx,
  output logic                           in_game,
  output logic                           turn_o,
  output logic                           busy,
  output logic                           illegal_pulse,
  output logic                           game_over,
  output logic [1:0]                     winner,
  output logic [CNT_W-1:0]               move_count,
  output logic [2*BOARD_N*BOARD_N-1:0]   board_state
);

  localparam int CELLS     = BOARD_N * BOARD_N;
  localparam int RC_W      = $clog2(BOARD_N);
  localparam int OFF_W     = $clog2(2*WIN_LEN-1);
  localparam int RUN_W     = $clog2(2*WIN_LEN);
  localparam int SCAN_LAST = 2*WIN_LEN - 2;

  state_e               state_q, state_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic                 turn_q, turn_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           winner_q, winner_d;
  logic                 over_q, over_d;
  logic                 in_game_q, in_game_d;
  logic                 busy_q, busy_d;
  logic                 ill_q, ill_d;
  logic [RC_W-1:0]      row_q, row_d, col_q, col_d;
  dir_e                 dir_q, dir_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [RUN_W-1:0]     run_q, run_d, run_base;
  logic                 win_q, win_d;
  logic                 in_bounds;
  logic [CELL_W-1:0]    probe_idx;
  logic [1:0]           pcode, key_cell, probe_cell;
  logic                 key_ok, hit, clear_game, opener;
  int                   key_int, kslot;
`ifdef TTT_ALT_FIRST_EN
  logic                 first_q, first_d;
`endif

  ttt_line_scan #(
    .BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN), .RC_W(RC_W), .OFF_W(OFF_W), .CELL_W(CELL_W)
  ) u_scan (
    .row(row_q), .col(col_q), .dir(dir_q), .off(off_q),
    .in_bounds(in_bounds), .probe_idx(probe_idx)
  );

  // Next-state, board update, scan bookkeeping and outcome evaluation.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    over_d     = over_q;
    in_game_d  = in_game_q;
    busy_d     = busy_q;
    ill_d      = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    dir_d      = dir_q;
    off_d      = off_q;
    run_d      = run_q;
    win_d      = win_q;
    clear_game = 1'b0;
`ifdef TTT_ALT_FIRST_EN
    first_d    = first_q;
    opener     = first_q;
`else
    opener     = 1'b0;
`endif
    pcode      = player_code(turn_q);
    key_int    = int'(key_idx);
    key_ok     = key_int < CELLS;
    kslot      = key_ok ? key_int : 0;
    key_cell   = board_q[2*kslot +: 2];
    probe_cell = board_q[2*int'(probe_idx) +: 2];
    hit        = in_bounds && (probe_cell == pcode);
    run_base   = (off_q == '0) ? '0 : run_q;

    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          clear_game = 1'b1;
          state_d    = WAIT_MOVE;
        end
      end
      WAIT_MOVE: begin
        if (start_pulse) begin
          clear_game = 1'b1;
        end else if (key_valid) begin
          if (key_ok && key_cell == CELL_EMPTY) begin
            board_d[2*kslot +: 2] = pcode;
            cnt_d   = cnt_q + CNT_W'(1);
            row_d   = RC_W'(key_int / BOARD_N);
            col_d   = RC_W'(key_int % BOARD_N);
            dir_d   = DIR_ROW;
            off_d   = '0;
            run_d   = '0;
            win_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SCAN;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      SCAN: begin
        run_d = hit ? run_base + RUN_W'(1) : '0;
        if (hit && (run_base + RUN_W'(1)) == RUN_W'(WIN_LEN)) win_d = 1'b1;
        if (off_q == OFF_W'(SCAN_LAST)) begin
          off_d = '0;
          if (dir_q == DIR_ADIAG) begin
            busy_d  = 1'b0;
            state_d = EVAL;
          end else begin
            dir_d = dir_e'(dir_q + 2'd1);
          end
        end else begin
          off_d = off_q + OFF_W'(1);
        end
      end
      EVAL: begin
        if (win_q) begin
          winner_d = pcode;
          over_d   = 1'b1;
          state_d  = OVER;
        end else if (cnt_q == CNT_W'(CELLS)) begin
          winner_d = WIN_NONE;
          over_d   = 1'b1;
          state_d  = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = WAIT_MOVE;
        end
      end
      OVER: begin
        if (start_pulse) begin
          clear_game = 1'b1;
          state_d    = WAIT_MOVE;
`ifdef TTT_ALT_FIRST_EN
          first_d    = ~first_q;
          opener     = ~first_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_game) begin
      board_d   = '0;
      cnt_d     = '0;
      winner_d  = WIN_NONE;
      over_d    = 1'b0;
      in_game_d = 1'b1;
      turn_d    = opener;
    end
  end

  // State and output registers; synchronous reset aborts any scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      board_q   <= '0;
      turn_q    <= 1'b0;
      cnt_q     <= '0;
      winner_q  <= WIN_NONE;
      over_q    <= 1'b0;
      in_game_q <= 1'b0;
      busy_q    <= 1'b0;
      ill_q     <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      dir_q     <= DIR_ROW;
      off_q     <= '0;
      run_q     <= '0;
      win_q     <= 1'b0;
`ifdef TTT_ALT_FIRST_EN
      first_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      over_q    <= over_d;
      in_game_q <= in_game_d;
      busy_q    <= busy_d;
      ill_q     <= ill_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dir_q     <= dir_d;
      off_q     <= off_d;
      run_q     <= run_d;
      win_q     <= win_d;
`ifdef TTT_ALT_FIRST_EN
      first_q   <= first_d;
`endif
    end
  end

  assign in_game       = in_game_q;
  assign turn_o        = turn_q;
  assign busy          = busy_q;
  assign illegal_pulse = ill_q;
  assign game_over     = over_q;
  assign winner        = winner_q;
  assign move_count    = cnt_q;
  assign board_state   = board_q;

endmodule

// File: tb/tb_ttt_game_core.sv
// Bench for ttt_game_core: a 3x3/K=3 and a 5x5/K=4 instance sharing stimulus,
// one held in reset while the other is exercised.
module tb_ttt_game_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst5, start_pulse, key_valid;
  logic [4:0] key;

  logic in3, turn3, busy3, ill3, over3;
  logic [1:0] win3;
  logic [3:0] cnt3;
  logic [17:0] b3;
  logic in5, turn5, busy5, ill5, over5;
  logic [1:0] win5;
  logic [4:0] cnt5;
  logic [49:0] b5;

  ttt_game_core #(.BOARD_N(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .rst(rst3), .start_pulse(start_pulse), .key_valid(key_valid),
    .key_idx(key[3:0]), .in_game(in3), .turn_o(turn3), .busy(busy3),
    .illegal_pulse(ill3), .game_over(over3), .winner(win3),
    .move_count(cnt3), .board_state(b3));

  ttt_game_core #(.BOARD_N(5), .WIN_LEN(4)) dut5 (
    .clk(clk), .rst(rst5), .start_pulse(start_pulse), .key_valid(key_valid),
    .key_idx(key), .in_game(in5), .turn_o(turn5), .busy(busy5),
    .illegal_pulse(ill5), .game_over(over5), .winner(win5),
    .move_count(cnt5), .board_state(b5));

  int sel;
  logic o_in, o_turn, o_busy, o_ill, o_over;
  logic [1:0] o_win;
  logic [4:0] o_cnt;
  logic [49:0] o_board;

  always_comb begin
    if (sel == 1) begin
      o_in = in5; o_turn = turn5; o_busy = busy5; o_ill = ill5; o_over = over5;
      o_win = win5; o_cnt = cnt5; o_board = b5;
    end else begin
      o_in = in3; o_turn = turn3; o_busy = busy3; o_ill = ill3; o_over = over3;
      o_win = win3; o_cnt = {1'b0, cnt3}; o_board = {32'b0, b3};
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (whole-board rules) ----------------
  int mb[64];
  int mn, mk, mcount, mwin;
  bit mturn, mover, min_game, mfirst;

  // Any K-in-a-row of stone p anywhere on the board.
  function automatic bit board_win(input int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          bit all;
          all = 1'b1;
          for (int s = 0; s < mk; s++) begin
            int rr, cc;
            rr = r + s*dr[d];
            cc = c + s*dc[d];
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) all = 1'b0;
            else if (mb[rr*mn+cc] != p) all = 1'b0;
          end
          if (all) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [49:0] mboard();
    logic [49:0] v;
    v = '0;
    for (int i = 0; i < mn*mn; i++) v[2*i +: 2] = 2'(mb[i]);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mb[i] = 0;
    mcount = 0; mwin = 0; mover = 1'b0;
  endtask

  // Reset both instances (start pulsed meanwhile), then free the chosen one.
  task automatic use_dut(input int s);
    sel = s;
    mn = (s == 1) ? 5 : 3;
    mk = (s == 1) ? 4 : 3;
    rst3 = 1'b1; rst5 = 1'b1; start_pulse = 1'b1; key_valid = 1'b0; key = '0;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    @(posedge clk); #1;
    model_clear(); mturn = 1'b0; min_game = 1'b0; mfirst = 1'b0;
    chk("rst_in_game", o_in, 0);
    chk("rst_board", o_board, 0);
    chk("rst_winner", o_win, 0);
    chk("rst_count", o_cnt, 0);
    chk("rst_turn", o_turn, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_over", o_over, 0);
    chk("rst_ill", o_ill, 0);
    if (s == 1) rst5 = 1'b0; else rst3 = 1'b0;
  endtask

  task automatic do_start();
    start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
`ifdef TTT_ALT_FIRST_EN
    if (mover) mfirst = !mfirst;
`endif
    model_clear(); mturn = mfirst; min_game = 1'b1;
    chk("start_in_game", o_in, 1);
    chk("start_board", o_board, 0);
    chk("start_turn", o_turn, mturn);
    chk("start_count", o_cnt, 0);
    chk("start_over", o_over, 0);
    chk("start_winner", o_win, 0);
  endtask

  // One key event; checks acceptance, scan latency and outcome against the model.
  task automatic press(input int idx, output logic seen_ill);
    int p, lat;
    key = 5'(idx); key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    seen_ill = o_ill;
    if (!min_game || mover) begin
      chk("ignored_ill", o_ill, 0);
      chk("frozen_board", o_board, mboard());
      chk("frozen_busy", o_busy, 0);
    end else if (idx >= mn*mn || mb[idx] != 0) begin
      chk("ill_set", o_ill, 1);
      chk("ill_board", o_board, mboard());
      chk("ill_turn", o_turn, mturn);
      chk("ill_count", o_cnt, mcount);
      @(posedge clk); #1;
      chk("ill_once", o_ill, 0);
    end else begin
      p = mturn ? 2 : 1;
      mb[idx] = p; mcount++;
      chk("place_ill", o_ill, 0);
      chk("place_board", o_board, mboard());
      chk("place_count", o_cnt, mcount);
      chk("scan_busy", o_busy, 1);
      lat = 4*(2*mk-1);
      repeat (lat) @(posedge clk);
      #1;
      chk("pre_eval_turn", o_turn, mturn);
      chk("pre_eval_over", o_over, 0);
      @(posedge clk); #1;
      if (board_win(p)) begin mwin = p; mover = 1'b1; end
      else if (mcount == mn*mn) mover = 1'b1;
      else mturn = !mturn;
      chk("eval_turn", o_turn, mturn);
      chk("eval_over", o_over, mover);
      chk("eval_winner", o_win, mwin);
      chk("eval_busy", o_busy, 0);
    end
  endtask

  typedef struct {
    int       sel;
    bit       start;
    int       idx;
    bit       ill;
    logic [1:0] win;
    bit       over;
    int       cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int s, input bit st, input int idx, input bit ill,
                              input logic [1:0] w, input bit ov, input int cnt);
    vec_t v;
    v.sel = s; v.start = st; v.idx = idx; v.ill = ill; v.win = w; v.over = ov; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  initial begin
    logic ill;
    int lat;
    rst3 = 1'b1; rst5 = 1'b1; start_pulse = 1'b0; key_valid = 1'b0; key = '0;
    sel = 0; mn = 3; mk = 3;

    // 3x3: row win for X, then a press in OVER is ignored
    add(0,1,0,0,2'b00,0,0);
    add(0,0,0,0,2'b00,0,1); add(0,0,3,0,2'b00,0,2); add(0,0,1,0,2'b00,0,3);
    add(0,0,4,0,2'b00,0,4); add(0,0,2,0,2'b01,1,5); add(0,0,8,0,2'b01,1,5);
    // illegal: occupied cell, out-of-range index
    add(0,1,0,0,2'b00,0,0); add(0,0,0,0,2'b00,0,1);
    add(0,0,0,1,2'b00,0,1); add(0,0,9,1,2'b00,0,1);
    // restart from WAIT_MOVE, then a full-board draw
    add(0,1,0,0,2'b00,0,0);
    add(0,0,0,0,2'b00,0,1); add(0,0,1,0,2'b00,0,2); add(0,0,2,0,2'b00,0,3);
    add(0,0,4,0,2'b00,0,4); add(0,0,3,0,2'b00,0,5); add(0,0,5,0,2'b00,0,6);
    add(0,0,7,0,2'b00,0,7); add(0,0,6,0,2'b00,0,8); add(0,0,8,0,2'b00,1,9);
    add(0,0,4,0,2'b00,1,9);
    // 5x5, K=4: index runs that wrap rows must not win; real row win later
    add(1,1,0,0,2'b00,0,0);
    add(1,0,3,0,2'b00,0,1);  add(1,0,20,0,2'b00,0,2); add(1,0,4,0,2'b00,0,3);
    add(1,0,21,0,2'b00,0,4); add(1,0,5,0,2'b00,0,5);  add(1,0,22,0,2'b00,0,6);
    add(1,0,6,0,2'b00,0,7);  add(1,0,24,0,2'b00,0,8); add(1,0,7,0,2'b00,0,9);
    add(1,0,0,0,2'b00,0,10); add(1,0,10,0,2'b00,0,11); add(1,0,1,0,2'b00,0,12);
    add(1,0,11,0,2'b00,0,13); add(1,0,2,0,2'b00,0,14); add(1,0,12,0,2'b00,0,15);
    add(1,0,15,0,2'b00,0,16); add(1,0,13,0,2'b01,1,17);

    use_dut(0);
    foreach (tbl[i]) begin
      if (tbl[i].sel != sel) use_dut(tbl[i].sel);
      if (tbl[i].start) do_start();
      else begin
        press(tbl[i].idx, ill);
        chk("tbl_ill", ill, tbl[i].ill);
        chk("tbl_winner", o_win, tbl[i].win);
        chk("tbl_over", o_over, tbl[i].over);
        chk("tbl_count", o_cnt, tbl[i].cnt);
      end
    end

    // Reset in the middle of a scan
    use_dut(0);
    do_start();
    key = 5'd4; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midscan_busy", o_busy, 1);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    model_clear(); mturn = 1'b0; min_game = 1'b0; mfirst = 1'b0;
    chk("midrst_in_game", o_in, 0);
    chk("midrst_board", o_board, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_count", o_cnt, 0);
    repeat (25) @(posedge clk);
    #1;
    chk("midrst_stay_idle", o_in, 0);
    chk("midrst_stay_over", o_over, 0);

    // Key and start during a scan are dropped
    do_start();
    key = 5'd0; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    mb[0] = 1; mcount = 1;
    repeat (3) @(posedge clk);
    #1;
    key = 5'd1; key_valid = 1'b1; start_pulse = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; start_pulse = 1'b0;
    chk("scan_key_ill", o_ill, 0);
    chk("scan_key_board", o_board, mboard());
    chk("scan_key_count", o_cnt, 1);
    lat = 4*(2*mk-1);
    repeat (lat-4) @(posedge clk);
    @(posedge clk); #1;
    mturn = !mturn;
    chk("scan_key_turn", o_turn, mturn);
    chk("scan_key_over", o_over, 0);
    chk("scan_key_board2", o_board, mboard());

    // Opener of the game after OVER
    do_start();
    press(0, ill); press(3, ill); press(1, ill); press(4, ill); press(2, ill);
    chk("alt_prev_over", o_over, 1);
    do_start();
`ifdef TTT_ALT_FIRST_EN
    chk("second_opener", o_turn, 1);
`else
    chk("second_opener", o_turn, 0);
`endif

    // Randomized games against the model
    for (int s = 0; s < 2; s++) begin
      use_dut(s);
      for (int g = 0; g < 3; g++) begin
        do_start();
        for (int m = 0; m < 80 && !mover; m++)
          press(int'($urandom_range(0, (s == 1) ? 31 : 15)), ill);
        chk("rand_game_over", o_over, 1);
        press(int'($urandom_range(0, (s == 1) ? 24 : 8)), ill);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ttt_game_core.md
Name: ttt_game_core

Overview:
Parametrised tic-tac-toe game engine: an N×N board with K-in-a-row win detection. Holds the main/game state, board contents, turn and move count. Accepts decoded keypad cell selections and a start key, and reports the outcome. Sits between keypad_scan (decoded key events) and the 7-segment / dot-matrix display drivers.

Parameters:
BOARD_N, 3, board side length; legal range 3..8
WIN_LEN, 3, consecutive stones needed to win; 3..BOARD_N
CELL_W, $clog2(BOARD_N*BOARD_N), width of the cell index (derived; do not override)
CNT_W, $clog2(BOARD_N*BOARD_N+1), width of the move counter (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
start_pulse  in  1  one-cycle start/new-game key event
key_valid  in  1  one-cycle cell-selection event
key_idx  in  CELL_W  selected cell, row-major (row*BOARD_N+col)
in_game  out  1  0 = main screen, 1 = game active or finished
turn_o  out  1  1 = O to move, 0 = X to move
busy  out  1  win check in progress
illegal_pulse  out  1  one-cycle flag: selection rejected
game_over  out  1  game finished
winner  out  2  00 none/draw, 01 X, 10 O
move_count  out  CNT_W  stones placed in current game
board_state  out  2*BOARD_N*BOARD_N  cell i at bits [2i+1:2i]: 00 empty, 01 X, 10 O

Behaviour:
- Reset, sampled on the clk rising edge while rst=1: state IDLE; in_game=0, turn_o=0, busy=0, illegal_pulse=0, game_over=0, winner=00, move_count=0, board_state all zero. Reset overrides all other inputs and aborts any operation in progress, including a scan in SCAN.
- FSM states: IDLE, WAIT_MOVE, SCAN, EVAL, OVER.
- IDLE: start_pulse clears the board, move_count and winner, sets turn_o=0 and in_game=1, and moves to WAIT_MOVE. key_valid is ignored here.
- WAIT_MOVE, start_pulse: restarts the game with the same clearing as in IDLE and stays in WAIT_MOVE. This has priority over a simultaneous key_valid.
- WAIT_MOVE, key_valid with key_idx < N*N and the cell empty: on the same edge, write the current player's code to the cell, increment move_count, and go to SCAN.
- WAIT_MOVE, key_valid with key_idx >= N*N or the cell occupied: illegal_pulse=1 for exactly one cycle; board, turn and count are unchanged.
- SCAN: busy=1. Checks 4 directions through the placed cell: row, column, diagonal, anti-diagonal.
  - Each direction steps through offsets -(WIN_LEN-1)..+(WIN_LEN-1), one cell per cycle, keeping a run counter of consecutive cells equal to the current player.
  - Any coordinate outside 0..N-1 counts as a mismatch and resets the run. There is no row wrap.
  - A win latches when the run reaches WIN_LEN.
  - SCAN always lasts exactly 4*(2*WIN_LEN-1) cycles; there is no early exit.
- SCAN, input handling: key_valid and start_pulse are dropped silently (no illegal_pulse).
- EVAL (one cycle):
  - Win: winner = current player code, game_over=1, go to OVER.
  - No win and move_count == N*N: winner=00, game_over=1, go to OVER.
  - Otherwise: toggle turn_o, go to WAIT_MOVE.
- Latency: a move accepted on edge E0 is visible on board_state after E0. The game_over/turn_o update becomes visible after edge E0 + 4*(2*WIN_LEN-1) + 1 (21 cycles for WIN_LEN=3).
- OVER: the board stays frozen and key_valid is ignored. start_pulse starts a new game (same clearing as in IDLE) and goes to WAIT_MOVE. in_game stays 1.
- All outputs are registered.

Optional Feature:
TTT_ALT_FIRST_EN
- Defined: an internal first_o flag selects who opens each game; a start from OVER toggles it, so openers alternate across games. A start from IDLE or WAIT_MOVE leaves it unchanged. rst clears it, so X opens after reset.
- Undefined: X always opens, and the flag logic is absent.

Decomposition:
- Package ttt_pkg holds:
  - cell codes CELL_EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10;
  - winner codes WIN_NONE, WIN_X, WIN_O;
  - state enum {IDLE, WAIT_MOVE, SCAN, EVAL, OVER};
  - direction enum {DIR_ROW, DIR_COL, DIR_DIAG, DIR_ADIAG}.
- One sub-module, ttt_line_scan: takes the placed row/col, direction and offset counter, and produces the in-bounds flag and probe cell index. It is the signed coordinate arithmetic only.

Test Plan:
- rst=1 for 2 cycles, with start_pulse also pulsed → in_game=0, board_state=0, winner=00, move_count=0.
- N=3,K=3: start, then X0,O3,X1,O4,X2 → winner=01 and game_over=1, visible 21 cycles after the X2 accept edge; move_count=5.
- After X0: key_idx=0 → illegal_pulse exactly one cycle, turn_o unchanged. Then key_idx=9 → illegal_pulse again; board unchanged.
- X0,O1,X2,O4,X3,O5,X7,O6,X8 → game_over=1, winner=00, move_count=9; a further key_valid is ignored.
- N=5,K=4: X at 3,4,5,6 with O at 20,21,22 → no win (no row wrap). X at 7 → still none. Horizontal X 10,11,12,13 → winner=01.
- rst asserted mid-SCAN, then a key pressed during SCAN without reset → respectively: reset gives IDLE and a zero board next cycle; the key during SCAN is dropped, with board and illegal_pulse unaffected.
- With TTT_ALT_FIRST_EN defined → second game after OVER opens with turn_o=1.
